mem_port_arbiter: RTL and testbench

- Shares the single memory port of the multicycle CPU subsystem between two requesters: the CPU (requester 0) and a debug/DMA loader (requester 1).
- Sequences each access as a request/ack transaction. Supports a configurable synchronous read latency.
- Drives a stall indication back to the CPU control path while a CPU access is outstanding.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter for the multicycle CPU subsystem.
// Serialises CPU and DMA/debug accesses onto one synchronous memory port.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int CPU_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    output logic          cpu_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          owner
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic          m_en_q;
    logic          m_we_q;
    logic [AW-1:0] m_adr_q;
    logic [DW-1:0] m_wdata_q;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          c_ack_q;
    logic          d_ack_q;
    logic          owner_q;
    logic          last_q;

    logic          gnt_dma_d;
    logic          sel_we_d;
    logic [AW-1:0] sel_adr_d;
    logic [DW-1:0] sel_wdata_d;

    // Grant decision: DMA wins alone, or on a tie when round-robin says so
    always_comb begin
        gnt_dma_d = 1'b0;
        if (d_req) begin
            if (!c_req) begin
                gnt_dma_d = 1'b1;
            end else if (CPU_PRIO == 0) begin
                gnt_dma_d = ~last_q;
            end
        end
        sel_we_d    = gnt_dma_d ? d_we    : c_we;
        sel_adr_d   = gnt_dma_d ? d_adr   : c_adr;
        sel_wdata_d = gnt_dma_d ? d_wdata : c_wdata;
    end

    // Transaction sequencer with registered memory strobes and acks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_adr_q   <= '0;
            m_wdata_q <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            owner_q   <= 1'b1;
            last_q    <= 1'b1;
        end else begin
            c_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            m_en_q  <= 1'b0;
            m_we_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (c_req || d_req) begin
                        owner_q   <= gnt_dma_d;
                        we_q      <= sel_we_d;
                        m_adr_q   <= sel_adr_d;
                        m_wdata_q <= sel_wdata_d;
                        m_en_q    <= 1'b1;
                        m_we_q    <= sel_we_d;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        c_ack_q <= ~owner_q;
                        d_ack_q <= owner_q;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        if (owner_q) begin
                            d_rdata_q <= m_rdata;
                        end else begin
                            c_rdata_q <= m_rdata;
                        end
                        c_ack_q <= ~owner_q;
                        d_ack_q <= owner_q;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    last_q  <= owner_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_en      = m_en_q;
    assign m_we      = m_we_q;
    assign m_adr     = m_adr_q;
    assign m_wdata   = m_wdata_q;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign c_ack     = c_ack_q;
    assign d_ack     = d_ack_q;
    assign owner     = owner_q;
    assign cpu_stall = c_req & ~c_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance with RD_LAT=2
// and a CPU-priority instance with RD_LAT=1.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    // round-robin instance (u_rr)
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_adr, c_wdata, d_adr, d_wdata;
    logic [31:0] c_rdata, d_rdata;
    logic        c_ack, d_ack, cpu_stall;
    logic        m_en, m_we, owner;
    logic [31:0] m_adr, m_wdata, m_rdata;

    // CPU-priority instance (u_pr)
    logic        p_c_req, p_c_we, p_d_req, p_d_we;
    logic [31:0] p_c_adr, p_c_wdata, p_d_adr, p_d_wdata;
    logic [31:0] p_c_rdata, p_d_rdata;
    logic        p_c_ack, p_d_ack, p_cpu_stall;
    logic        p_m_en, p_m_we, p_owner;
    logic [31:0] p_m_adr, p_m_wdata, p_m_rdata;

    int n_cmp;
    int n_err;

    logic [31:0] rd_p1, rd_p2;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .CPU_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack), .cpu_stall(cpu_stall),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .owner(owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .CPU_PRIO(1)) u_pr (
        .clk(clk), .rst(rst),
        .c_req(p_c_req), .c_we(p_c_we), .c_adr(p_c_adr), .c_wdata(p_c_wdata),
        .c_rdata(p_c_rdata), .c_ack(p_c_ack), .cpu_stall(p_cpu_stall),
        .d_req(p_d_req), .d_we(p_d_we), .d_adr(p_d_adr), .d_wdata(p_d_wdata),
        .d_rdata(p_d_rdata), .d_ack(p_d_ack),
        .m_en(p_m_en), .m_we(p_m_we), .m_adr(p_m_adr), .m_wdata(p_m_wdata),
        .m_rdata(p_m_rdata), .owner(p_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
    endfunction

    // two-cycle read memory for the round-robin instance
    always @(posedge clk) begin
        if (m_en && !m_we) rd_p1 <= memval(m_adr);
        rd_p2 <= rd_p1;
    end
    assign m_rdata   = rd_p2;
    assign p_m_rdata = 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic exp_own [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rd_p1 = '0;
        rd_p2 = '0;
        rst = 1'b1;
        c_req = 0; c_we = 0; c_adr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_adr = 0; d_wdata = 0;
        p_c_req = 0; p_c_we = 0; p_c_adr = 0; p_c_wdata = 0;
        p_d_req = 0; p_d_we = 0; p_d_adr = 0; p_d_wdata = 0;
        exp_own[0] = 1'b0; exp_own[1] = 1'b1;
        exp_own[2] = 1'b0; exp_own[3] = 1'b1;

        // reset state
        tick;
        chk("rst_m_en", m_en, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_owner", owner, 1);
        chk("rst_m_adr", m_adr, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_acks", {c_ack, d_ack}, 0);
        rst = 1'b0;
        tick;

        // CPU write
        c_we = 1; c_adr = 32'h10; c_wdata = 32'hDEAD_BEEF; c_req = 1;
        #1;
        chk("w_c0_stall", cpu_stall, 1);
        chk("w_c0_m_en", m_en, 0);
        tick;
        chk("w_c1_m_en", m_en, 1);
        chk("w_c1_m_we", m_we, 1);
        chk("w_c1_m_adr", m_adr, 32'h10);
        chk("w_c1_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("w_c1_stall", cpu_stall, 1);
        chk("w_c1_c_ack", c_ack, 0);
        chk("w_c1_owner", owner, 0);
        tick;
        chk("w_c2_c_ack", c_ack, 1);
        chk("w_c2_d_ack", d_ack, 0);
        chk("w_c2_m_en", m_en, 0);
        chk("w_c2_m_we", m_we, 0);
        chk("w_c2_stall", cpu_stall, 0);
        c_req = 0;
        tick;
        chk("w_c3_c_ack", c_ack, 0);
        chk("w_c3_m_en", m_en, 0);

        // CPU read, two-cycle latency
        c_we = 0; c_adr = 32'h20; c_req = 1;
        tick;
        chk("r_c1_m_en", m_en, 1);
        chk("r_c1_m_we", m_we, 0);
        chk("r_c1_m_adr", m_adr, 32'h20);
        tick;
        chk("r_c2_m_en", m_en, 0);
        chk("r_c2_c_ack", c_ack, 0);
        tick;
        chk("r_c3_c_ack", c_ack, 0);
        tick;
        chk("r_c4_c_ack", c_ack, 1);
        chk("r_c4_c_rdata", c_rdata, 32'h1234_5678);
        chk("r_c4_stall", cpu_stall, 0);
        c_req = 0;
        tick;
        chk("r_c5_c_ack", c_ack, 0);
        chk("r_c5_c_rdata", c_rdata, 32'h1234_5678);
        chk("r_c5_d_rdata", d_rdata, 0);

        // reset, then both writing continuously under round-robin
        rst = 1'b1;
        #1;
        chk("rr_rst_owner", owner, 1);
        chk("rr_rst_c_rdata", c_rdata, 0);
        tick;
        rst = 1'b0;
        c_we = 1; c_adr = 32'h100; c_wdata = 32'h1;
        d_we = 1; d_adr = 32'h200; d_wdata = 32'h2;
        c_req = 1; d_req = 1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("rr_owner", owner, exp_own[k]);
            chk("rr_m_en", m_en, 1);
            chk("rr_m_adr", m_adr, exp_own[k] ? 32'h200 : 32'h100);
            tick;
            chk("rr_c_ack", c_ack, !exp_own[k]);
            chk("rr_d_ack", d_ack, exp_own[k]);
            if (k == 3) begin
                c_req = 0;
                d_req = 0;
            end
            tick;
            chk("rr_idle_acks", {c_ack, d_ack}, 0);
        end
        tick;
        chk("rr_quiet_m_en", m_en, 0);

        // CPU fixed priority
        p_c_we = 1; p_c_adr = 32'h400; p_d_we = 1; p_d_adr = 32'h500;
        p_c_req = 1; p_d_req = 1;
        tick;
        chk("pr_c1_owner", p_owner, 0);
        chk("pr_c1_m_adr", p_m_adr, 32'h400);
        tick;
        chk("pr_c2_acks", {p_c_ack, p_d_ack}, 2'b10);
        tick;
        tick;
        chk("pr_c4_owner", p_owner, 0);
        chk("pr_c4_stall", p_cpu_stall, 1);
        tick;
        chk("pr_c5_acks", {p_c_ack, p_d_ack}, 2'b10);
        p_c_req = 0;
        tick;
        chk("pr_c6_m_en", p_m_en, 0);
        tick;
        chk("pr_c7_owner", p_owner, 1);
        chk("pr_c7_m_adr", p_m_adr, 32'h500);
        chk("pr_c7_m_en", p_m_en, 1);
        tick;
        chk("pr_c8_acks", {p_c_ack, p_d_ack}, 2'b01);
        p_d_req = 0;
        tick;
        chk("pr_c9_d_ack", p_d_ack, 0);

        // DMA read completes into d_rdata only
        d_we = 0; d_adr = 32'h30; d_req = 1;
        tick;
        chk("dr_c1_owner", owner, 1);
        chk("dr_c1_m_en", m_en, 1);
        tick;
        tick;
        tick;
        chk("dr_c4_d_ack", d_ack, 1);
        chk("dr_c4_d_rdata", d_rdata, 32'hA5A5_0030);
        chk("dr_c4_c_rdata", c_rdata, 0);
        d_req = 0;
        tick;
        chk("dr_c5_d_ack", d_ack, 0);

        // reset during a DMA read wait cycle
        d_adr = 32'h20; d_req = 1;
        tick;
        chk("rw_c1_m_en", m_en, 1);
        tick;
        rst = 1'b1;
        #1;
        chk("rw_m_en", m_en, 0);
        chk("rw_d_ack", d_ack, 0);
        chk("rw_d_rdata", d_rdata, 0);
        chk("rw_owner", owner, 1);
        d_req = 0;
        tick;
        rst = 1'b0;
        tick;
        tick;
        chk("rw_after_d_ack", d_ack, 0);
        chk("rw_after_m_en", m_en, 0);

        // CPU read after reset; fields change after grant
        c_we = 0; c_adr = 32'h20; c_req = 1;
        tick;
        c_adr = 32'h44; c_we = 1;
        #1;
        chk("lat_m_adr", m_adr, 32'h20);
        chk("lat_m_we", m_we, 0);
        chk("lat_m_en", m_en, 1);
        tick;
        tick;
        tick;
        chk("lat_c_ack", c_ack, 1);
        chk("lat_c_rdata", c_rdata, 32'h1234_5678);
        chk("lat_d_rdata", d_rdata, 0);
        c_req = 0;
        tick;

        // CPU request withdrawn while DMA owns the port
        d_we = 1; d_adr = 32'h300; d_req = 1;
        tick;
        chk("dw_c1_owner", owner, 1);
        c_we = 0; c_req = 1;
        #1;
        chk("dw_c1_stall", cpu_stall, 1);
        tick;
        chk("dw_c2_d_ack", d_ack, 1);
        c_req = 0;
        d_req = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("drop_m_en", m_en, 0);
            chk("drop_c_ack", c_ack, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
